// File: rtl/mac_dotp_pkg.sv
// Shared types and constants for the streaming dot-product engine.
// Saturation limits are only consumed when MAC_DOTP_SAT_EN is defined.
package mac_dotp_pkg;

  localparam int unsigned DEF_DATA_W    = 16;
  localparam int unsigned DEF_ACC_W     = 32;
  localparam int unsigned DEF_NUM_TERMS = 3;

  // Widest accumulator the limit helper can describe.
  localparam int unsigned SAT_MAX_W = 256;

  typedef logic [SAT_MAX_W-1:0] sat_word_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } win_state_t;

  // Upper or lower clamp value of an acc_w-bit accumulator, right-aligned.
  function automatic sat_word_t sat_limit(input int unsigned acc_w,
                                          input logic        is_signed,
                                          input logic        upper);
    sat_word_t ones;
    sat_word_t hi;
    ones = '1;
    hi   = is_signed ? (ones >> (SAT_MAX_W - acc_w + 1)) : (ones >> (SAT_MAX_W - acc_w));
    if (upper) begin
      return hi;
    end
    return is_signed ? (sat_word_t'(1) << (acc_w - 1)) : '0;
  endfunction

endpackage

// File: rtl/mac_dotp_mult_stage.sv
// Registered DATA_W x DATA_W multiplier that carries valid/first/last tags
// alongside the product.
module mac_dotp_mult_stage
  import mac_dotp_pkg::*;
#(
  parameter int unsigned DATA_W      = DEF_DATA_W,
  parameter int unsigned SIGNED_MODE = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid,
  input  logic                  first,
  input  logic                  last,
  input  logic [DATA_W-1:0]     x,
  input  logic [DATA_W-1:0]     y,
  output logic                  prod_valid,
  output logic                  prod_first,
  output logic                  prod_last,
  output logic [2*DATA_W-1:0]   prod
);

  localparam int unsigned PROD_W = 2 * DATA_W;

  logic [PROD_W-1:0] prod_c;

  // Operands are widened first so the product is computed at full width.
  if (SIGNED_MODE != 0) begin : g_signed
    logic signed [PROD_W-1:0] xs;
    logic signed [PROD_W-1:0] ys;
    assign xs     = PROD_W'($signed(x));
    assign ys     = PROD_W'($signed(y));
    assign prod_c = xs * ys;
  end else begin : g_unsigned
    logic [PROD_W-1:0] xu;
    logic [PROD_W-1:0] yu;
    assign xu     = PROD_W'(x);
    assign yu     = PROD_W'(y);
    assign prod_c = xu * yu;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prod_valid <= 1'b0;
      prod_first <= 1'b0;
      prod_last  <= 1'b0;
      prod       <= '0;
    end else begin
      prod_valid <= valid;
      prod_first <= first;
      prod_last  <= last;
      prod       <= prod_c;
    end
  end

endmodule

// File: rtl/mac_dot_product.sv
// Streaming NUM_TERMS-point dot product with one-cycle result strobe.
// Define MAC_DOTP_SAT_EN for saturating accumulation and the o_ovf flag.
module mac_dot_product
  import mac_dotp_pkg::*;
#(
  parameter int unsigned DATA_W      = DEF_DATA_W,
  parameter int unsigned NUM_TERMS   = DEF_NUM_TERMS,
  parameter int unsigned ACC_W       = DEF_ACC_W,
  parameter int unsigned SIGNED_MODE = 0
) (
  input  logic                         i_Clk,
  input  logic                         i_Rst,
  input  logic                         i_valid,
  input  logic [DATA_W-1:0]            i_x,
  input  logic [DATA_W-1:0]            i_y,
  input  logic                         i_clear,
  output logic [ACC_W-1:0]             o_sum,
  output logic                         o_valid,
  output logic [$clog2(NUM_TERMS)-1:0] o_term,
  output logic                         o_busy
`ifdef MAC_DOTP_SAT_EN
  ,
  output logic                         o_ovf
`endif
);

  localparam int unsigned TERM_W    = $clog2(NUM_TERMS);
  localparam int unsigned PROD_W    = 2 * DATA_W;
  localparam int unsigned LAST_TERM = NUM_TERMS - 1;

  win_state_t        state;
  win_state_t        state_next;
  logic [TERM_W-1:0] term_next;
  logic              accept;
  logic              take_first;
  logic              take_last;

  logic              p_valid;
  logic              p_first;
  logic              p_last;
  logic [PROD_W-1:0] prod;

  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  acc_next;
  logic [ACC_W-1:0]  base;
  logic [ACC_W-1:0]  addend;
  logic              s2_en;

  // Window FSM and term counter; a clear discards any pair offered with it.
  always_comb begin
    state_next = state;
    term_next  = o_term;
    accept     = i_valid && !i_clear;
    take_first = (o_term == '0);
    take_last  = (o_term == TERM_W'(LAST_TERM));
    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_next = ST_ACCUM;
          term_next  = o_term + TERM_W'(1);
        end
      end
      ST_ACCUM: begin
        if (i_clear) begin
          state_next = ST_IDLE;
          term_next  = '0;
        end else if (i_valid) begin
          if (take_last) begin
            state_next = ST_IDLE;
            term_next  = '0;
          end else begin
            term_next  = o_term + TERM_W'(1);
          end
        end
      end
      default: begin
        state_next = ST_IDLE;
        term_next  = '0;
      end
    endcase
  end

  mac_dotp_mult_stage #(
    .DATA_W      (DATA_W),
    .SIGNED_MODE (SIGNED_MODE)
  ) u_mult (
    .clk        (i_Clk),
    .rst        (i_Rst),
    .valid      (accept),
    .first      (take_first),
    .last       (take_last),
    .x          (i_x),
    .y          (i_y),
    .prod_valid (p_valid),
    .prod_first (p_first),
    .prod_last  (p_last),
    .prod       (prod)
  );

  if (SIGNED_MODE != 0) begin : g_sext
    assign addend = ACC_W'($signed(prod));
  end else begin : g_zext
    assign addend = ACC_W'(prod);
  end

  // A clear kills a partial-window product in stage 1; a completed one survives.
  assign s2_en = p_valid && (p_last || !i_clear);

`ifdef MAC_DOTP_SAT_EN
  localparam logic [ACC_W-1:0] SAT_HI = ACC_W'(sat_limit(ACC_W, SIGNED_MODE != 0, 1'b1));
  localparam logic [ACC_W-1:0] SAT_LO = ACC_W'(sat_limit(ACC_W, SIGNED_MODE != 0, 1'b0));

  logic [ACC_W-1:0] raw_sum;
  logic             carry;
  logic             ovf_base;
  logic             over;
  logic             ovf_next;

  // Once a window has clamped, its accumulator is frozen until the next first term.
  always_comb begin
    base     = p_first ? '0 : acc;
    ovf_base = p_first ? 1'b0 : o_ovf;
    {carry, raw_sum} = (ACC_W+1)'(base) + (ACC_W+1)'(addend);
    if (SIGNED_MODE != 0) begin
      over = (base[ACC_W-1] == addend[ACC_W-1]) && (raw_sum[ACC_W-1] != base[ACC_W-1]);
    end else begin
      over = carry;
    end
    acc_next = raw_sum;
    ovf_next = 1'b0;
    if (ovf_base) begin
      acc_next = base;
      ovf_next = 1'b1;
    end else if (over) begin
      acc_next = ((SIGNED_MODE != 0) && addend[ACC_W-1]) ? SAT_LO : SAT_HI;
      ovf_next = 1'b1;
    end
  end
`else
  always_comb begin
    base     = p_first ? '0 : acc;
    acc_next = base + addend;
  end
`endif

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state   <= ST_IDLE;
      o_term  <= '0;
      o_busy  <= 1'b0;
      acc     <= '0;
      o_sum   <= '0;
      o_valid <= 1'b0;
`ifdef MAC_DOTP_SAT_EN
      o_ovf   <= 1'b0;
`endif
    end else begin
      state   <= state_next;
      o_term  <= term_next;
      o_busy  <= (state_next == ST_ACCUM) || accept;
      o_valid <= 1'b0;
      if (s2_en) begin
        acc <= acc_next;
`ifdef MAC_DOTP_SAT_EN
        o_ovf <= ovf_next;
`endif
        if (p_last) begin
          o_sum   <= acc_next;
          o_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mac_dot_product.sv
// Directed bench for mac_dot_product: unsigned and signed instances share stimulus
// and are checked every cycle against a window-level arithmetic model.
module tb_mac_dot_product;

  localparam int unsigned DW = 16;
  localparam int unsigned N  = 3;
  localparam int unsigned AW = 32;
`ifdef MAC_DOTP_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  localparam logic [63:0] U_MAX = 64'h0000_0000_FFFF_FFFF;
  localparam longint      S_MAX = 64'sh0000_0000_7FFF_FFFF;
  localparam longint      S_MIN = -64'sh0000_0000_8000_0000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          valid = 1'b0;
  logic          clear = 1'b0;
  logic [DW-1:0] x = '0;
  logic [DW-1:0] y = '0;

  logic [AW-1:0] o_sum_u, o_sum_s;
  logic          o_valid_u, o_valid_s;
  logic [1:0]    o_term_u, o_term_s;
  logic          o_busy_u, o_busy_s;
  logic          o_ovf_u, o_ovf_s;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mac_dot_product #(.DATA_W(DW), .NUM_TERMS(N), .ACC_W(AW), .SIGNED_MODE(0)) u_dut (
    .i_Clk(clk), .i_Rst(rst), .i_valid(valid), .i_x(x), .i_y(y), .i_clear(clear),
    .o_sum(o_sum_u), .o_valid(o_valid_u), .o_term(o_term_u), .o_busy(o_busy_u)
`ifdef MAC_DOTP_SAT_EN
    , .o_ovf(o_ovf_u)
`endif
  );

  mac_dot_product #(.DATA_W(DW), .NUM_TERMS(N), .ACC_W(AW), .SIGNED_MODE(1)) u_dut_s (
    .i_Clk(clk), .i_Rst(rst), .i_valid(valid), .i_x(x), .i_y(y), .i_clear(clear),
    .o_sum(o_sum_s), .o_valid(o_valid_s), .o_term(o_term_s), .o_busy(o_busy_s)
`ifdef MAC_DOTP_SAT_EN
    , .o_ovf(o_ovf_s)
`endif
  );

`ifndef MAC_DOTP_SAT_EN
  assign o_ovf_u = 1'b0;
  assign o_ovf_s = 1'b0;
`endif

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Window model: plain integer sums, strobe one edge after the last pair is taken.
  bit            model_ready = 1'b0;
  int            m_cnt;
  bit            m_pend, took;
  logic [63:0]   wu, pu;
  longint        ws, ps;
  bit            ou, os;
  logic [AW-1:0] p_sum_u, p_sum_s;
  bit            p_ovf_u, p_ovf_s;
  logic [AW-1:0] e_sum_u, e_sum_s;
  bit            e_valid, e_busy, e_ovf_u, e_ovf_s;
  int            e_term;

  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        m_cnt = 0; m_pend = 1'b0; e_valid = 1'b0; e_sum_u = '0; e_sum_s = '0;
        e_term = 0; e_busy = 1'b0; e_ovf_u = 1'b0; e_ovf_s = 1'b0;
        model_ready = 1'b1;
      end else begin
        e_valid = m_pend;
        if (m_pend) begin
          e_sum_u = p_sum_u; e_sum_s = p_sum_s; e_ovf_u = p_ovf_u; e_ovf_s = p_ovf_s;
          m_pend = 1'b0;
        end
        took = 1'b0;
        if (clear) begin
          m_cnt = 0;
        end else if (valid) begin
          if (m_cnt == 0) begin wu = '0; ws = 0; ou = 1'b0; os = 1'b0; end
          pu = 64'(x) * 64'(y);
          ps = longint'($signed(x)) * longint'($signed(y));
          if (!(SAT && ou)) begin
            wu = wu + pu;
            if (SAT && wu > U_MAX) begin wu = U_MAX; ou = 1'b1; end
          end
          if (!(SAT && os)) begin
            ws = ws + ps;
            if (SAT && ws > S_MAX) begin ws = S_MAX; os = 1'b1; end
            else if (SAT && ws < S_MIN) begin ws = S_MIN; os = 1'b1; end
          end
          m_cnt++;
          took = 1'b1;
          if (m_cnt == N) begin
            m_pend = 1'b1; p_sum_u = wu[31:0]; p_sum_s = ws[31:0];
            p_ovf_u = ou; p_ovf_s = os; m_cnt = 0;
          end
        end
        e_term = m_cnt;
        e_busy = (m_cnt != 0) || took;
      end
    end
  end

  // Per-cycle comparison on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (model_ready) begin
        check("valid_u", o_valid_u, e_valid);
        check("sum_u",   o_sum_u,   e_sum_u);
        check("term_u",  o_term_u,  e_term);
        check("busy_u",  o_busy_u,  e_busy);
        check("valid_s", o_valid_s, e_valid);
        check("sum_s",   o_sum_s,   e_sum_s);
        check("term_s",  o_term_s,  e_term);
        check("busy_s",  o_busy_s,  e_busy);
        if (SAT && e_valid) begin
          check("ovf_u", o_ovf_u, e_ovf_u);
          check("ovf_s", o_ovf_s, e_ovf_s);
        end
      end
    end
  end

  // Strobe capture for the hand-computed expectations.
  int            n_str_u = 0;
  int            n_str_s = 0;
  logic [AW-1:0] last_u, last_s;
  logic          last_ovf_u;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (o_valid_u === 1'b1) begin n_str_u++; last_u = o_sum_u; last_ovf_u = o_ovf_u; end
      if (o_valid_s === 1'b1) begin n_str_s++; last_s = o_sum_s; end
    end
  end

  task automatic send(input logic [DW-1:0] xv, input logic [DW-1:0] yv);
    @(negedge clk);
    valid = 1'b1; clear = 1'b0; x = xv; y = yv;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      valid = 1'b0; clear = 1'b0;
    end
  endtask

  task automatic do_clear(input logic with_valid);
    @(negedge clk);
    valid = with_valid; clear = 1'b1; x = 16'hDEAD; y = 16'hBEEF;
  endtask

  task automatic wait_strobes(input string name, input int target);
    int n;
    n = 0;
    while (n_str_u < target && n < 20) begin
      idle(1);
      n++;
    end
    idle(2);
    check(name, 64'(n_str_u), 64'(target));
  endtask

  task automatic legacy();
    send(16'hB1C5, 16'hCE5F);
    send(16'h5489, 16'hA76C);
    send(16'h1D86, 16'h1DEA);
  endtask

  initial begin
    int base;
    // Reset values
    repeat (2) @(negedge clk);
    check("rst_sum",   o_sum_u,   0);
    check("rst_valid", o_valid_u, 0);
    check("rst_term",  o_term_u,  0);
    check("rst_busy",  o_busy_u,  0);
    rst = 1'b0;
    idle(2);

    // Legacy window: strobe exactly one cycle, the edge after the last sample
    base = n_str_u;
    legacy();
    idle(1);
    check("t1_early",    o_valid_u, 0);
    check("t1_busy",     o_busy_u,  1);
    idle(1);
    check("t1_strobe",   o_valid_u, 1);
    check("t1_sum",      o_sum_u,   32'hCA0AB163);
    idle(1);
    check("t1_one_cyc",  o_valid_u, 0);
    check("t1_hold",     o_sum_u,   32'hCA0AB163);
    wait_strobes("t1_count", base + 1);

    // Gaps between pairs
    base = n_str_u;
    send(16'hB1C5, 16'hCE5F);
    idle(1);
    check("t2_term_gap1", o_term_u, 1);
    send(16'h5489, 16'hA76C);
    idle(3);
    check("t2_term_gap3", o_term_u, 2);
    send(16'h1D86, 16'h1DEA);
    wait_strobes("t2_count", base + 1);
    check("t2_sum", last_u, 32'hCA0AB163);

    // Back-to-back windows, no bubble
    base = n_str_u;
    legacy();
    send(16'h0001, 16'h0001);
    send(16'h0001, 16'h0001);
    check("t3_strobe1", o_valid_u, 1);
    check("t3_sum1",    o_sum_u,   32'hCA0AB163);
    send(16'h0001, 16'h0001);
    check("t3_gap",     o_valid_u, 0);
    idle(2);
    check("t3_strobe2", o_valid_u, 1);
    check("t3_sum2",    o_sum_u,   32'h00000003);
    wait_strobes("t3_count", base + 2);

    // Abort after two pairs (pair offered with the clear is discarded), then a full window
    base = n_str_u;
    send(16'hB1C5, 16'hCE5F);
    send(16'h5489, 16'hA76C);
    do_clear(1'b1);
    idle(3);
    check("t4_no_strobe", 64'(n_str_u), 64'(base));
    check("t4_held_sum",  o_sum_u,      32'h00000003);
    legacy();
    wait_strobes("t4_count", base + 1);
    check("t4_sum", last_u, 32'hCA0AB163);

    // Clear right after a completed window: that window still strobes
    base = n_str_u;
    send(16'h0001, 16'h0002);
    send(16'h0001, 16'h0002);
    send(16'h0001, 16'h0002);
    do_clear(1'b1);
    wait_strobes("t4b_count", base + 1);
    check("t4b_sum", last_u, 32'h00000006);

    // Reset mid-window
    send(16'hB1C5, 16'hCE5F);
    send(16'h5489, 16'hA76C);
    @(negedge clk);
    valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    check("t4r_sum",  o_sum_u,  0);
    check("t4r_term", o_term_u, 0);
    check("t4r_busy", o_busy_u, 0);
    rst = 1'b0;
    idle(2);
    base = n_str_u;
    legacy();
    wait_strobes("t4r_count", base + 1);
    check("t4r_sum2", last_u, 32'hCA0AB163);

    // Signed operands
    base = n_str_s;
    repeat (3) send(16'hFFFE, 16'h0003);
    idle(4);
    check("t5_count", 64'(n_str_s), 64'(base + 1));
    check("t5_sum_s", last_s, 32'hFFFFFFEE);

    // Overflow window, then a clean one
    base = n_str_u;
    repeat (3) send(16'hFFFF, 16'hFFFF);
    wait_strobes("t6_count", base + 1);
    check("t6_sum_s", last_s, 32'h00000003);
`ifdef MAC_DOTP_SAT_EN
    check("t6_sum_sat", last_u,     32'hFFFFFFFF);
    check("t6_ovf",     last_ovf_u, 1);
`else
    check("t6_sum_wrap", last_u, 32'hFFFA0003);
`endif
    repeat (3) send(16'h0001, 16'h0001);
    wait_strobes("t6_clean_count", base + 2);
    check("t6_clean_sum", last_u, 32'h00000003);
`ifdef MAC_DOTP_SAT_EN
    check("t6_clean_ovf", last_ovf_u, 0);
`endif

    idle(3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, failures so far %0d", n_fail);
    $fatal(1, "watchdog");
  end

endmodule
